// File: rtl/fifo_sync_core.sv
// fifo_sync_core: single-clock FIFO with registered read data and level/threshold status.
// Define FIFO_ERR_FLAGS_EN to add the sticky overflow/underflow outputs.
module fifo_sync_core #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(MEM_DEPTH):0] level,
  output logic                       almost_full,
  output logic                       almost_empty
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [AW:0] AfLevel = AF_LEVEL[AW:0];
  localparam logic [AW:0] AeLevel = AE_LEVEL[AW:0];

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [AW:0]           wrPtr_q, wrPtr_d;
  logic [AW:0]           rdPtr_q, rdPtr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [AW-1:0]         wrAddr;
  logic [AW-1:0]         rdAddr;
  logic                  wrAccept;
  logic                  rdAccept;

  assign wrAddr = wrPtr_q[AW-1:0];
  assign rdAddr = rdPtr_q[AW-1:0];

  // The extra pointer MSB tells a full buffer apart from an empty one.
  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrAddr == rdAddr) && (wrPtr_q[AW] != rdPtr_q[AW]);
  assign level = wrPtr_q - rdPtr_q;

  assign almost_full  = (level >= AfLevel);
  assign almost_empty = (level <= AeLevel);

  assign wrAccept = wr_en && !full;
  assign rdAccept = rd_en && !empty;

  always_comb begin
    wrPtr_d = wrPtr_q + {{AW{1'b0}}, wrAccept};
    rdPtr_d = rdPtr_q + {{AW{1'b0}}, rdAccept};
    dout_d  = rdAccept ? mem[rdAddr] : dout_q;
  end

  always_ff @(posedge clk) begin
    if (wrAccept) begin
      mem[wrAddr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      dout_q  <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q || (wr_en && full);
    underflow_d = underflow_q || (rd_en && empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sync_core.sv
// tb_fifo_sync_core: table-driven directed bench for fifo_sync_core at default parameters,
// plus a hand-written asynchronous-reset sequence.
module tb_fifo_sync_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       almost_full;
  logic       almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  fifo_sync_core #(
    .DATA_WIDTH(8),
    .MEM_DEPTH (16),
    .AF_LEVEL  (14),
    .AE_LEVEL  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .din         (din),
    .rd_en       (rd_en),
    .dout        (dout),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       isReset;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] expDout;
    logic       expEmpty;
    logic       expFull;
    logic [4:0] expLevel;
    logic       expAf;
    logic       expAe;
    logic       expOvf;
    logic       expUnf;
  } vec_t;

  vec_t vecs[$];

  // Occupancy tracker used only while building the table; data expectations are given by hand.
  int   mLvl = 0;
  logic mOvf = 1'b0;
  logic mUnf = 1'b0;

  function automatic void addVec(input logic isReset, input logic wr, input logic rd,
                                 input logic [7:0] d, input logic [7:0] expD);
    vec_t v;
    int   wOk;
    int   rOk;
    if (isReset) begin
      mLvl = 0;
      mOvf = 1'b0;
      mUnf = 1'b0;
    end else begin
      wOk = (wr && mLvl < 16) ? 1 : 0;
      rOk = (rd && mLvl > 0) ? 1 : 0;
      if (wr && mLvl == 16) mOvf = 1'b1;
      if (rd && mLvl == 0) mUnf = 1'b1;
      mLvl = mLvl + wOk - rOk;
    end
    v.isReset  = isReset;
    v.wr       = wr;
    v.rd       = rd;
    v.din      = d;
    v.expDout  = expD;
    v.expLevel = 5'(mLvl);
    v.expEmpty = (mLvl == 0);
    v.expFull  = (mLvl == 16);
    v.expAf    = (mLvl >= 14);
    v.expAe    = (mLvl <= 2);
    v.expOvf   = mOvf;
    v.expUnf   = mUnf;
    vecs.push_back(v);
  endfunction

  task automatic checkField(input int idx, input string name,
                            input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL step %0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.isReset) begin
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
    end else begin
      wr_en = v.wr;
      rd_en = v.rd;
      din   = v.din;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    checkField(idx, "dout",         32'(dout),         32'(v.expDout));
    checkField(idx, "empty",        32'(empty),        32'(v.expEmpty));
    checkField(idx, "full",         32'(full),         32'(v.expFull));
    checkField(idx, "level",        32'(level),        32'(v.expLevel));
    checkField(idx, "almost_full",  32'(almost_full),  32'(v.expAf));
    checkField(idx, "almost_empty", 32'(almost_empty), 32'(v.expAe));
`ifdef FIFO_ERR_FLAGS_EN
    checkField(idx, "overflow",     32'(overflow),     32'(v.expOvf));
    checkField(idx, "underflow",    32'(underflow),    32'(v.expUnf));
`endif
  endtask

  task automatic doWrite(input logic [7:0] d);
    wr_en = 1'b1;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic doRead();
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;

    // Reset, 15 writes then 15 reads; thresholds are crossed on the way.
    addVec(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 15; i++) addVec(1'b0, 1'b1, 1'b0, 8'(8'h10 + i), 8'h00);
    for (int i = 0; i < 15; i++) addVec(1'b0, 1'b0, 1'b1, 8'h00, 8'(8'h10 + i));
    // Fill to 16, drop a 17th write, then drain; dout holds 0x1E while filling.
    for (int i = 0; i < 16; i++) addVec(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i), 8'h1E);
    addVec(1'b0, 1'b1, 1'b0, 8'hFF, 8'h1E);
    for (int i = 0; i < 16; i++) addVec(1'b0, 1'b0, 1'b1, 8'h00, 8'(8'hA0 + i));
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 8'hAF);
    // Read on empty after reset, then simultaneous write+read on empty.
    addVec(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    addVec(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    addVec(1'b0, 1'b1, 1'b1, 8'h55, 8'h00);
    addVec(1'b0, 1'b0, 1'b1, 8'h00, 8'h55);
    // Hold level 5 for 20 simultaneous cycles so both pointers wrap.
    for (int i = 0; i < 5; i++) addVec(1'b0, 1'b1, 1'b0, 8'(8'h60 + i), 8'h55);
    for (int i = 0; i < 20; i++) addVec(1'b0, 1'b1, 1'b1, 8'(8'h65 + i), 8'(8'h60 + i));
    for (int i = 0; i < 5; i++) addVec(1'b0, 1'b0, 1'b1, 8'h00, 8'(8'h74 + i));

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k]);
      checkOutput(k, vecs[k]);
    end

    // Asynchronous reset with 8 words stored and a non-zero dout.
    for (int i = 0; i < 8; i++) doWrite(8'(8'h80 + i));
    doRead();
    doWrite(8'h88);
    checkField(1000, "pre_rst_dout",  32'(dout),  32'h80);
    checkField(1000, "pre_rst_level", 32'(level), 32'd8);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkField(1001, "async_empty",  32'(empty),        32'd1);
    checkField(1001, "async_level",  32'(level),        32'd0);
    checkField(1001, "async_dout",   32'(dout),         32'h00);
    checkField(1001, "async_full",   32'(full),         32'd0);
    checkField(1001, "async_ae",     32'(almost_empty), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    doWrite(8'h3C);
    checkField(1002, "post_rst_level", 32'(level), 32'd1);
    doRead();
    checkField(1003, "post_rst_dout",  32'(dout),  32'h3C);
    checkField(1003, "post_rst_empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
